// File: rtl/rs_entry_table.sv
// -----------------------------------------------------------------------------
// rs_entry_table
// Reservation-station entry array. Accepts one dispatched op per cycle into the
// one-hot entry chosen upstream, captures missing operands from the common data
// bus, and issues the lowest-index ready entry to the execution unit over a
// valid/ready handshake.
//
// Ports
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   flush_i                       synchronous squash of every entry
//   alloc_i, alloc_sel_i          dispatch request and its one-hot target entry
//   op_i, dst_tag_i               opcode / destination tag of the dispatched op
//   src{1,2}_rdy/tag/val_i        per-source readiness, producer tag, value
//   cdb_valid_i/tag_i/data_i      result broadcast
//   entry_free_o, full_o          per-entry free vector, no entry free
//   issue_valid_o, issue_ready_i  issue handshake
//   issue_op/dst_tag/src1/src2_o  fields of the issuing entry (0 when idle)
//
// Entry state table
//   state    | meaning
//   ST_FREE  | entry empty, may be allocated
//   ST_WAIT  | holds an op, at least one source still waiting on the CDB
//   ST_READY | holds an op with both sources captured, eligible for issue
// -----------------------------------------------------------------------------
module rs_entry_table #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4,
  parameter int DATA_W      = 32,
  parameter int OP_W        = 4,
  // Enables the simulation check on dropped allocation requests.
  parameter bit ALLOC_CHECK = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   alloc_i,
  input  logic [NUM_ENTRIES-1:0] alloc_sel_i,
  input  logic [OP_W-1:0]        op_i,
  input  logic [TAG_W-1:0]       dst_tag_i,
  input  logic                   src1_rdy_i,
  input  logic [TAG_W-1:0]       src1_tag_i,
  input  logic [DATA_W-1:0]      src1_val_i,
  input  logic                   src2_rdy_i,
  input  logic [TAG_W-1:0]       src2_tag_i,
  input  logic [DATA_W-1:0]      src2_val_i,
  input  logic                   cdb_valid_i,
  input  logic [TAG_W-1:0]       cdb_tag_i,
  input  logic [DATA_W-1:0]      cdb_data_i,
  output logic [NUM_ENTRIES-1:0] entry_free_o,
  output logic                   full_o,
  output logic                   issue_valid_o,
  input  logic                   issue_ready_i,
  output logic [OP_W-1:0]        issue_op_o,
  output logic [TAG_W-1:0]       issue_dst_tag_o,
  output logic [DATA_W-1:0]      issue_src1_o,
  output logic [DATA_W-1:0]      issue_src2_o
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } entry_state_e;

  entry_state_e      state_q [NUM_ENTRIES];
  logic [OP_W-1:0]   op_q    [NUM_ENTRIES];
  logic [TAG_W-1:0]  dst_q   [NUM_ENTRIES];
  logic              rdy1_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]  tag1_q  [NUM_ENTRIES];
  logic [DATA_W-1:0] val1_q  [NUM_ENTRIES];
  logic              rdy2_q  [NUM_ENTRIES];
  logic [TAG_W-1:0]  tag2_q  [NUM_ENTRIES];
  logic [DATA_W-1:0] val2_q  [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0] busy;
  logic [NUM_ENTRIES-1:0] cand;
  logic [NUM_ENTRIES-1:0] wake1;
  logic [NUM_ENTRIES-1:0] wake2;
  logic [NUM_ENTRIES-1:0] alloc_we;
  logic [NUM_ENTRIES-1:0] issue_hit;

  logic             sel_onehot;
  logic             alloc_ok;
  logic             issue_valid;
  logic [IDX_W-1:0] issue_idx;
  logic             issue_fire;

  // Dispatch-time operand resolution, including same-cycle CDB bypass.
  logic              byp1, byp2;
  logic              in_rdy1, in_rdy2;
  logic [DATA_W-1:0] in_val1, in_val2;

  always_comb begin
    busy  = '0;
    cand  = '0;
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      busy[i]  = (state_q[i] != ST_FREE);
      cand[i]  = (state_q[i] == ST_READY);
      // Only waiting entries listen to the bus; a ready source never re-captures.
      wake1[i] = (state_q[i] == ST_WAIT) && !rdy1_q[i] && cdb_valid_i &&
                 (tag1_q[i] == cdb_tag_i);
      wake2[i] = (state_q[i] == ST_WAIT) && !rdy2_q[i] && cdb_valid_i &&
                 (tag2_q[i] == cdb_tag_i);
    end
  end

  // Allocation is honoured only for an exactly one-hot select hitting a free entry.
  assign sel_onehot = (alloc_sel_i != '0) &&
                      ((alloc_sel_i & (alloc_sel_i - NUM_ENTRIES'(1))) == '0);
  assign alloc_ok   = alloc_i && sel_onehot && ((alloc_sel_i & ~busy) != '0);
  assign alloc_we   = alloc_ok ? alloc_sel_i : '0;

  assign byp1    = !src1_rdy_i && cdb_valid_i && (cdb_tag_i == src1_tag_i);
  assign byp2    = !src2_rdy_i && cdb_valid_i && (cdb_tag_i == src2_tag_i);
  assign in_rdy1 = src1_rdy_i || byp1;
  assign in_rdy2 = src2_rdy_i || byp2;
  assign in_val1 = src1_rdy_i ? src1_val_i : (byp1 ? cdb_data_i : '0);
  assign in_val2 = src2_rdy_i ? src2_val_i : (byp2 ? cdb_data_i : '0);

  // Lowest-index ready entry wins; scanning downward lets the lowest overwrite.
  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (cand[i]) begin
        issue_valid = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  assign issue_fire = issue_valid && issue_ready_i;

  always_comb begin
    issue_hit = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      issue_hit[i] = issue_fire && (issue_idx == IDX_W'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        op_q[i]    <= '0;
        dst_q[i]   <= '0;
        rdy1_q[i]  <= 1'b0;
        tag1_q[i]  <= '0;
        val1_q[i]  <= '0;
        rdy2_q[i]  <= 1'b0;
        tag2_q[i]  <= '0;
        val2_q[i]  <= '0;
      end
    end else if (flush_i) begin
      // Flush overrides allocation, wakeup and issue in the same cycle.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        rdy1_q[i]  <= 1'b0;
        rdy2_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        case (state_q[i])
          ST_FREE: begin
            if (alloc_we[i]) begin
              op_q[i]    <= op_i;
              dst_q[i]   <= dst_tag_i;
              rdy1_q[i]  <= in_rdy1;
              tag1_q[i]  <= src1_tag_i;
              val1_q[i]  <= in_val1;
              rdy2_q[i]  <= in_rdy2;
              tag2_q[i]  <= src2_tag_i;
              val2_q[i]  <= in_val2;
              state_q[i] <= (in_rdy1 && in_rdy2) ? ST_READY : ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (wake1[i]) begin
              rdy1_q[i] <= 1'b1;
              val1_q[i] <= cdb_data_i;
            end
            if (wake2[i]) begin
              rdy2_q[i] <= 1'b1;
              val2_q[i] <= cdb_data_i;
            end
            if ((rdy1_q[i] || wake1[i]) && (rdy2_q[i] || wake2[i])) begin
              state_q[i] <= ST_READY;
            end
          end
          ST_READY: begin
            if (issue_hit[i]) begin
              state_q[i] <= ST_FREE;
              rdy1_q[i]  <= 1'b0;
              rdy2_q[i]  <= 1'b0;
            end
          end
          default: state_q[i] <= ST_FREE;
        endcase
      end
    end
  end

  assign entry_free_o    = ~busy;
  assign full_o          = &busy;
  assign issue_valid_o   = issue_valid;
  assign issue_op_o      = issue_valid ? op_q[issue_idx]   : '0;
  assign issue_dst_tag_o = issue_valid ? dst_q[issue_idx]  : '0;
  assign issue_src1_o    = issue_valid ? val1_q[issue_idx] : '0;
  assign issue_src2_o    = issue_valid ? val2_q[issue_idx] : '0;

  // A dropped request points at an upstream selection bug; a flushed cycle is
  // an intentional drop and is not reported.
  always_ff @(posedge clk_i) begin
    if (ALLOC_CHECK && rst_ni && alloc_i && !flush_i) begin
      assert (alloc_ok)
        else $error("rs_entry_table: alloc dropped, sel=%b busy=%b", alloc_sel_i, busy);
    end
  end

endmodule

// File: tb/tb_rs_entry_table.sv
module tb_rs_entry_table;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          alloc_i;
  logic [N-1:0]  alloc_sel_i;
  logic [OW-1:0] op_i;
  logic [TW-1:0] dst_tag_i;
  logic          src1_rdy_i, src2_rdy_i;
  logic [TW-1:0] src1_tag_i, src2_tag_i;
  logic [DW-1:0] src1_val_i, src2_val_i;
  logic          cdb_valid_i;
  logic [TW-1:0] cdb_tag_i;
  logic [DW-1:0] cdb_data_i;
  logic [N-1:0]  entry_free_o;
  logic          full_o;
  logic          issue_valid_o;
  logic          issue_ready_i;
  logic [OW-1:0] issue_op_o;
  logic [TW-1:0] issue_dst_tag_o;
  logic [DW-1:0] issue_src1_o, issue_src2_o;

  always #5 clk_i = ~clk_i;

  // Dropped allocations are exercised deliberately here, so the in-design check is off.
  rs_entry_table #(
    .NUM_ENTRIES(N), .TAG_W(TW), .DATA_W(DW), .OP_W(OW), .ALLOC_CHECK(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .alloc_i(alloc_i), .alloc_sel_i(alloc_sel_i), .op_i(op_i), .dst_tag_i(dst_tag_i),
    .src1_rdy_i(src1_rdy_i), .src1_tag_i(src1_tag_i), .src1_val_i(src1_val_i),
    .src2_rdy_i(src2_rdy_i), .src2_tag_i(src2_tag_i), .src2_val_i(src2_val_i),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .entry_free_o(entry_free_o), .full_o(full_o),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_op_o(issue_op_o), .issue_dst_tag_o(issue_dst_tag_o),
    .issue_src1_o(issue_src1_o), .issue_src2_o(issue_src2_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an entry is a record; it is issuable when busy with both sources held.
  logic          m_busy [N];
  logic [OW-1:0] m_op   [N];
  logic [TW-1:0] m_dst  [N];
  logic          m_r1   [N], m_r2 [N];
  logic [TW-1:0] m_t1   [N], m_t2 [N];
  logic [DW-1:0] m_v1   [N], m_v2 [N];

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 1'b0; m_r1[i] = 1'b0; m_r2[i] = 1'b0;
    end
  endtask

  function automatic int m_sel();
    for (int i = 0; i < N; i++)
      if (m_busy[i] && m_r1[i] && m_r2[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    int s;
    int idx;
    logic busy_old [N];
    s = m_sel();
    for (int i = 0; i < N; i++) busy_old[i] = m_busy[i];
    if (flush_i) begin
      for (int i = 0; i < N; i++) m_busy[i] = 1'b0;
      return;
    end
    for (int i = 0; i < N; i++) begin
      if (busy_old[i] && cdb_valid_i) begin
        if (!m_r1[i] && m_t1[i] == cdb_tag_i) begin m_r1[i] = 1'b1; m_v1[i] = cdb_data_i; end
        if (!m_r2[i] && m_t2[i] == cdb_tag_i) begin m_r2[i] = 1'b1; m_v2[i] = cdb_data_i; end
      end
    end
    if (s >= 0 && issue_ready_i) m_busy[s] = 1'b0;
    if (alloc_i && $countones(alloc_sel_i) == 1) begin
      idx = 0;
      for (int i = 0; i < N; i++) if (alloc_sel_i[i]) idx = i;
      if (!busy_old[idx]) begin
        m_busy[idx] = 1'b1;
        m_op[idx]   = op_i;
        m_dst[idx]  = dst_tag_i;
        m_t1[idx]   = src1_tag_i;
        m_t2[idx]   = src2_tag_i;
        m_r1[idx]   = src1_rdy_i || (cdb_valid_i && cdb_tag_i == src1_tag_i);
        m_v1[idx]   = src1_rdy_i ? src1_val_i : cdb_data_i;
        m_r2[idx]   = src2_rdy_i || (cdb_valid_i && cdb_tag_i == src2_tag_i);
        m_v2[idx]   = src2_rdy_i ? src2_val_i : cdb_data_i;
      end
    end
  endtask

  task automatic check_model(input string ctx);
    int s;
    logic [N-1:0] efree;
    s = m_sel();
    for (int i = 0; i < N; i++) efree[i] = !m_busy[i];
    chk({ctx, "_free"},  32'(entry_free_o),   32'(efree));
    chk({ctx, "_full"},  32'(full_o),         32'(efree == '0));
    chk({ctx, "_valid"}, 32'(issue_valid_o),  32'(s >= 0));
    chk({ctx, "_op"},    32'(issue_op_o),     (s >= 0) ? 32'(m_op[s])  : 32'd0);
    chk({ctx, "_dst"},   32'(issue_dst_tag_o),(s >= 0) ? 32'(m_dst[s]) : 32'd0);
    chk({ctx, "_src1"},  issue_src1_o,        (s >= 0) ? m_v1[s] : 32'd0);
    chk({ctx, "_src2"},  issue_src2_o,        (s >= 0) ? m_v2[s] : 32'd0);
  endtask

  task automatic idle();
    flush_i = 0; alloc_i = 0; alloc_sel_i = '0; op_i = '0; dst_tag_i = '0;
    src1_rdy_i = 0; src1_tag_i = '0; src1_val_i = '0;
    src2_rdy_i = 0; src2_tag_i = '0; src2_val_i = '0;
    cdb_valid_i = 0; cdb_tag_i = '0; cdb_data_i = '0; issue_ready_i = 0;
  endtask

  // One clock edge; the model sees the same inputs the DUT saw at that edge.
  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic set_alloc(input logic [N-1:0] sel, input logic [OW-1:0] op,
                           input logic [TW-1:0] dst,
                           input logic r1, input logic [TW-1:0] t1, input logic [DW-1:0] v1,
                           input logic r2, input logic [TW-1:0] t2, input logic [DW-1:0] v2);
    alloc_i = 1; alloc_sel_i = sel; op_i = op; dst_tag_i = dst;
    src1_rdy_i = r1; src1_tag_i = t1; src1_val_i = v1;
    src2_rdy_i = r2; src2_tag_i = t2; src2_val_i = v2;
  endtask

  typedef struct {
    logic          alloc;
    logic [N-1:0]  sel;
    logic [OW-1:0] op;
    logic [TW-1:0] dst;
    logic          r1;
    logic [TW-1:0] t1;
    logic [DW-1:0] v1;
    logic          r2;
    logic [TW-1:0] t2;
    logic [DW-1:0] v2;
    logic          cdbv;
    logic [TW-1:0] cdbt;
    logic [DW-1:0] cdbd;
    logic          ird;
    logic          fl;
    logic [N-1:0]  e_free;
    logic          e_full;
    logic          e_valid;
    logic [OW-1:0] e_op;
    logic [DW-1:0] e_s1;
    logic [DW-1:0] e_s2;
  } vec_t;

  vec_t vt [9];

  initial begin
    logic [N-1:0] one_sel;
    one_sel = 4'b0001;

    //            al sel     op dst r1 t1 v1     r2 t2 v2      cv ct cd      ird fl  free     fu va op  s1      s2
    vt[0] = '{1'b0, 4'b0000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,  0, 0, 32'h0,  0, 0, 4'b1111, 0, 0, 0, 32'h0,  32'h0};
    vt[1] = '{1'b1, 4'b0001, 3, 2, 1, 0, 32'h5, 1, 0, 32'h7,  0, 0, 32'h0,  0, 0, 4'b1110, 0, 1, 3, 32'h5,  32'h7};
    vt[2] = '{1'b0, 4'b0000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 4'b1111, 0, 0, 0, 32'h0,  32'h0};
    vt[3] = '{1'b1, 4'b0010, 4, 3, 0, 9, 32'h0, 1, 0, 32'h11, 0, 0, 32'h0,  0, 0, 4'b1101, 0, 0, 0, 32'h0,  32'h0};
    vt[4] = '{1'b0, 4'b0000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,  1, 5, 32'h55, 0, 0, 4'b1101, 0, 0, 0, 32'h0,  32'h0};
    vt[5] = '{1'b0, 4'b0000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,  1, 9, 32'hAA, 0, 0, 4'b1101, 0, 1, 4, 32'hAA, 32'h11};
    vt[6] = '{1'b0, 4'b0000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 4'b1111, 0, 0, 0, 32'h0,  32'h0};
    vt[7] = '{1'b1, 4'b0100, 6, 7, 0, 6, 32'h0, 1, 0, 32'h22, 1, 6, 32'h66, 0, 0, 4'b1011, 0, 1, 6, 32'h66, 32'h22};
    vt[8] = '{1'b0, 4'b0000, 0, 0, 0, 0, 32'h0, 0, 0, 32'h0,  0, 0, 32'h0,  1, 0, 4'b1111, 0, 0, 0, 32'h0,  32'h0};

    // Reset state before any clock edge.
    idle();
    rst_ni = 1'b0;
    model_reset();
    #2;
    chk("rst_free",  32'(entry_free_o),  32'hF);
    chk("rst_full",  32'(full_o),        32'h0);
    chk("rst_valid", 32'(issue_valid_o), 32'h0);
    chk("rst_src1",  issue_src1_o,       32'h0);
    @(posedge clk_i); @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // Directed vectors.
    for (int v = 0; v < 9; v++) begin
      idle();
      alloc_i = vt[v].alloc; alloc_sel_i = vt[v].sel; op_i = vt[v].op; dst_tag_i = vt[v].dst;
      src1_rdy_i = vt[v].r1; src1_tag_i = vt[v].t1; src1_val_i = vt[v].v1;
      src2_rdy_i = vt[v].r2; src2_tag_i = vt[v].t2; src2_val_i = vt[v].v2;
      cdb_valid_i = vt[v].cdbv; cdb_tag_i = vt[v].cdbt; cdb_data_i = vt[v].cdbd;
      issue_ready_i = vt[v].ird; flush_i = vt[v].fl;
      tick();
      chk($sformatf("vec%0d_free", v),  32'(entry_free_o),  32'(vt[v].e_free));
      chk($sformatf("vec%0d_full", v),  32'(full_o),        32'(vt[v].e_full));
      chk($sformatf("vec%0d_valid", v), 32'(issue_valid_o), 32'(vt[v].e_valid));
      chk($sformatf("vec%0d_op", v),    32'(issue_op_o),    32'(vt[v].e_op));
      chk($sformatf("vec%0d_src1", v),  issue_src1_o,       vt[v].e_s1);
      chk($sformatf("vec%0d_src2", v),  issue_src2_o,       vt[v].e_s2);
    end

    // Fill all entries with src1 pending; entries 1 and 3 wait on the same tag.
    for (int i = 0; i < N; i++) begin
      idle();
      set_alloc(one_sel << i, OW'(8 + i), TW'(i + 1),
                1'b0, (i == 3) ? TW'(11) : TW'(10 + i), 32'h0,
                1'b1, TW'(0), 32'(100 + i));
      tick();
    end
    idle();
    chk("fill_free",  32'(entry_free_o),  32'h0);
    chk("fill_full",  32'(full_o),        32'h1);
    chk("fill_valid", 32'(issue_valid_o), 32'h0);

    // Allocation onto a busy entry is dropped.
    set_alloc(4'b0100, 4'd15, 4'd15, 1'b1, 4'd0, 32'hDEAD, 1'b1, 4'd0, 32'hBEEF);
    tick();
    idle();
    chk("drop_free",  32'(entry_free_o),  32'h0);
    chk("drop_valid", 32'(issue_valid_o), 32'h0);

    // Entries 1 and 3 wake together; entry 1 is presented and held while stalled.
    cdb_valid_i = 1; cdb_tag_i = 4'd11; cdb_data_i = 32'hB1;
    tick();
    idle();
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("hold%0d_valid", c), 32'(issue_valid_o),   32'h1);
      chk($sformatf("hold%0d_dst", c),   32'(issue_dst_tag_o), 32'h2);
      chk($sformatf("hold%0d_src1", c),  issue_src1_o,         32'hB1);
      chk($sformatf("hold%0d_src2", c),  issue_src2_o,         32'd101);
      if (c < 3) tick();
    end
    issue_ready_i = 1;
    tick();
    idle();
    chk("second_dst",  32'(issue_dst_tag_o), 32'h4);
    chk("second_src2", issue_src2_o,         32'd103);
    chk("second_free", 32'(entry_free_o),    32'b0010);

    // A lower-index entry becoming ready takes over the presented slot; entry 2 kept its op.
    cdb_valid_i = 1; cdb_tag_i = 4'd12; cdb_data_i = 32'hC2;
    tick();
    idle();
    chk("lower_dst",  32'(issue_dst_tag_o), 32'h3);
    chk("lower_op",   32'(issue_op_o),      32'd10);
    chk("lower_src1", issue_src1_o,         32'hC2);

    // Flush with three entries busy beats a concurrent issue and allocation.
    flush_i = 1; issue_ready_i = 1;
    set_alloc(4'b0010, 4'd1, 4'd1, 1'b1, 4'd0, 32'h1, 1'b1, 4'd0, 32'h2);
    tick();
    idle();
    chk("flush_free",  32'(entry_free_o),  32'hF);
    chk("flush_valid", 32'(issue_valid_o), 32'h0);
    chk("flush_src1",  issue_src1_o,       32'h0);

    // Asynchronous reset mid-operation clears state without a clock edge.
    set_alloc(4'b0001, 4'd2, 4'd5, 1'b1, 4'd0, 32'h9, 1'b1, 4'd0, 32'hA);
    tick();
    idle();
    chk("pre_rst_valid", 32'(issue_valid_o), 32'h1);
    #1 rst_ni = 1'b0;
    #1;
    chk("async_rst_free",  32'(entry_free_o),  32'hF);
    chk("async_rst_valid", 32'(issue_valid_o), 32'h0);
    model_reset();
    #1 rst_ni = 1'b1;

    // Randomized traffic against the reference model.
    for (int c = 0; c < 1500; c++) begin
      idle();
      alloc_i = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) < 8) alloc_sel_i = one_sel << $urandom_range(0, N - 1);
      else                          alloc_sel_i = N'($urandom);
      op_i        = OW'($urandom);
      dst_tag_i   = TW'($urandom);
      src1_rdy_i  = ($urandom_range(0, 2) == 0);
      src1_tag_i  = TW'($urandom_range(0, 7));
      src1_val_i  = $urandom;
      src2_rdy_i  = ($urandom_range(0, 2) == 0);
      src2_tag_i  = TW'($urandom_range(0, 7));
      src2_val_i  = $urandom;
      cdb_valid_i = ($urandom_range(0, 1) == 1);
      cdb_tag_i   = TW'($urandom_range(0, 7));
      cdb_data_i  = $urandom;
      issue_ready_i = ($urandom_range(0, 4) < 3);
      flush_i     = ($urandom_range(0, 49) == 0);
      tick();
      check_model($sformatf("rnd%0d", c));
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
